wb_master_arb: RTL and testbench



---
 rtl/wb_master_arb.sv | 89 ++++++++
 tb/tb_wb_master_arb.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/wb_master_arb.sv
// wb_master_arb: two-master Wishbone-style arbiter with fair alternation and a bus watchdog
module wb_master_arb #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_cyc,
  input  logic        m0_we,
  input  logic [3:0]  m0_strb,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_data_i,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_data_o,
  input  logic        m1_cyc,
  input  logic        m1_we,
  input  logic [3:0]  m1_strb,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_data_i,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_data_o,
  output logic        s_cyc,
  output logic        s_we,
  output logic [3:0]  s_strb,
  output logic [31:0] s_addr,
  output logic [31:0] s_data_o,
  input  logic        s_ack,
  input  logic [31:0] s_data_i,
  output logic [1:0]  grant,
  output logic [7:0]  tmo_cnt
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1, ABORT} state_t;
  state_t state;
  logic last_owner, owner, own0, own1, own, own_cyc;
  logic [7:0] wd;
  assign own0 = state == OWN0;
  assign own1 = state == OWN1;
  assign own = own0 | own1;
  assign own_cyc = owner ? m1_cyc : m0_cyc;
  assign grant = {own1, own0};
  assign s_cyc = own & (own1 ? m1_cyc : m0_cyc);
  assign s_we = own & (own1 ? m1_we : m0_we);
  assign s_strb = own ? (own1 ? m1_strb : m0_strb) : '0;
  assign s_addr = own ? (own1 ? m1_addr : m0_addr) : '0;
  assign s_data_o = own ? (own1 ? m1_data_i : m0_data_i) : '0;
  assign m0_ack = own0 & s_ack;
  assign m1_ack = own1 & s_ack;
  assign m0_err = (state == ABORT) & ~owner;
  assign m1_err = (state == ABORT) & owner;
  assign m0_data_o = own0 ? s_data_i : '0;
  assign m1_data_o = own1 ? s_data_i : '0;
  // grant one whole transfer at a time; ties go to the master that did not own last
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last_owner <= 1'b1;
      owner <= 1'b0;
      wd <= '0;
      tmo_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          wd <= '0;
          if (m0_cyc && (!m1_cyc || last_owner)) begin
            state <= OWN0;
            owner <= 1'b0;
          end else if (m1_cyc) begin
            state <= OWN1;
            owner <= 1'b1;
          end
        end
        OWN0, OWN1: begin
          wd <= wd + 8'd1;
          if (s_ack) begin
            last_owner <= owner;
            state <= IDLE;
          end else if (!own_cyc) state <= IDLE;
          else if (wd == 8'(TIMEOUT - 1)) state <= ABORT;
        end
        ABORT: begin
          last_owner <= owner;
          if (tmo_cnt != 8'hff) tmo_cnt <= tmo_cnt + 8'd1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_wb_master_arb.sv
// tb_wb_master_arb: directed self-checking bench for wb_master_arb
module tb_wb_master_arb;
  logic clk = 0, rst = 1;
  logic m0_cyc = 0, m0_we = 0, m1_cyc = 0, m1_we = 0, s_ack = 0;
  logic [3:0] m0_strb = 0, m1_strb = 0, s_strb;
  logic [31:0] m0_addr = 0, m0_data_i = 0, m1_addr = 0, m1_data_i = 0, s_data_i = 0;
  logic [31:0] m0_data_o, m1_data_o, s_addr, s_data_o;
  logic m0_ack, m0_err, m1_ack, m1_err, s_cyc, s_we;
  logic [1:0] grant;
  logic [7:0] tmo_cnt;
  int n_chk = 0, n_fail = 0;

  wb_master_arb #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc(m0_cyc), .m0_we(m0_we), .m0_strb(m0_strb), .m0_addr(m0_addr), .m0_data_i(m0_data_i),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_data_o(m0_data_o),
    .m1_cyc(m1_cyc), .m1_we(m1_we), .m1_strb(m1_strb), .m1_addr(m1_addr), .m1_data_i(m1_data_i),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_data_o(m1_data_o),
    .s_cyc(s_cyc), .s_we(s_we), .s_strb(s_strb), .s_addr(s_addr), .s_data_o(s_data_o),
    .s_ack(s_ack), .s_data_i(s_data_i), .grant(grant), .tmo_cnt(tmo_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    repeat (2) tick;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_s_cyc", 32'(s_cyc), 0);
    chk("rst_s_addr", s_addr, 0);
    chk("rst_tmo", 32'(tmo_cnt), 0);
    chk("rst_m0_ack", 32'(m0_ack), 0);
    rst = 0;
    tick;
    m0_cyc = 1; m1_cyc = 1; s_ack = 1;
    for (int i = 0; i < 6; i++) begin
      tick;
      chk("fair_grant", 32'(grant), (i % 2 == 0) ? 1 : 2);
      chk("fair_ack", 32'({m1_ack, m0_ack}), (i % 2 == 0) ? 1 : 2);
      tick;
      chk("fair_idle_grant", 32'(grant), 0);
      chk("fair_idle_ack", 32'({m1_ack, m0_ack}), 0);
    end
    m0_cyc = 0; m1_cyc = 0; s_ack = 0;
    tick;
    m0_cyc = 1; m0_addr = 32'h100;
    tick;
    chk("rd_grant", 32'(grant), 1);
    chk("rd_s_cyc", 32'(s_cyc), 1);
    chk("rd_s_addr", s_addr, 32'h100);
    tick;
    chk("rd_wait_ack", 32'(m0_ack), 0);
    s_ack = 1; s_data_i = 32'h12345678;
    #1;
    chk("rd_ack", 32'(m0_ack), 1);
    chk("rd_data", m0_data_o, 32'h12345678);
    chk("rd_m1_ack", 32'(m1_ack), 0);
    chk("rd_m1_data", m1_data_o, 0);
    m0_cyc = 0;
    tick;
    s_ack = 0;
    chk("rd_done_grant", 32'(grant), 0);
    m0_addr = 32'hdead; m0_strb = 4'hf; m0_data_i = 32'h11111111;
    m1_cyc = 1; m1_we = 1; m1_strb = 4'h3; m1_addr = 32'h404; m1_data_i = 32'hcafef00d;
    tick;
    chk("wr_grant", 32'(grant), 2);
    chk("wr_s_cyc", 32'(s_cyc), 1);
    chk("wr_s_we", 32'(s_we), 1);
    chk("wr_s_strb", 32'(s_strb), 3);
    chk("wr_s_addr", s_addr, 32'h404);
    chk("wr_s_data", s_data_o, 32'hcafef00d);
    s_ack = 1;
    #1;
    chk("wr_m1_ack", 32'(m1_ack), 1);
    chk("wr_m0_ack", 32'(m0_ack), 0);
    m1_cyc = 0;
    tick;
    s_ack = 0;
    m0_cyc = 1;
    repeat (8) tick;
    chk("tmo_pre_err", 32'(m0_err), 0);
    chk("tmo_pre_grant", 32'(grant), 1);
    tick;
    chk("tmo_err", 32'(m0_err), 1);
    chk("tmo_ack", 32'(m0_ack), 0);
    chk("tmo_s_cyc", 32'(s_cyc), 0);
    chk("tmo_m1_err", 32'(m1_err), 0);
    m0_cyc = 0;
    tick;
    chk("tmo_err_once", 32'(m0_err), 0);
    chk("tmo_cnt1", 32'(tmo_cnt), 1);
    m1_cyc = 1;
    tick;
    chk("tmo_next_grant", 32'(grant), 2);
    s_ack = 1;
    #1;
    chk("tmo_next_ack", 32'(m1_ack), 1);
    m1_cyc = 0;
    tick;
    s_ack = 0;
    m0_cyc = 1;
    repeat (8) tick;
    s_ack = 1;
    #1;
    chk("exp_ack", 32'(m0_ack), 1);
    chk("exp_err", 32'(m0_err), 0);
    m0_cyc = 0;
    tick;
    s_ack = 0;
    chk("exp_after_err", 32'(m0_err), 0);
    chk("exp_tmo_cnt", 32'(tmo_cnt), 1);
    m1_cyc = 1;
    tick;
    chk("mid_grant", 32'(grant), 2);
    tick;
    rst = 1; m0_cyc = 1;
    tick;
    s_ack = 1;
    #1;
    chk("mid_grant0", 32'(grant), 0);
    chk("mid_s_cyc", 32'(s_cyc), 0);
    chk("mid_s_we", 32'(s_we), 0);
    chk("mid_s_strb", 32'(s_strb), 0);
    chk("mid_s_addr", s_addr, 0);
    chk("mid_s_data", s_data_o, 0);
    chk("mid_acks", 32'({m1_ack, m0_ack}), 0);
    chk("mid_errs", 32'({m1_err, m0_err}), 0);
    chk("mid_data_o", m1_data_o | m0_data_o, 0);
    chk("mid_tmo", 32'(tmo_cnt), 0);
    rst = 0; m1_cyc = 0; s_ack = 0;
    tick;
    chk("post_rst_grant", 32'(grant), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
